// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer: combinational IF-stage lookup, EX-stage update and misprediction redirect.
// Optional build macro BTB_STATS_EN adds lookup/hit/mispredict statistics counters.
module btb_predictor #(
    parameter int IDX_BITS = 4,
    parameter int CNT_INIT = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IF_PC,
    output logic        PredHit,
    output logic        PredTaken,
    output logic [31:0] PredPC,
    input  logic        EX_Valid,
    input  logic [31:0] EX_PC,
    input  logic        EX_BranchSig,
    input  logic        EX_Uncond,
    input  logic        EX_Branched,
    input  logic [31:0] EX_NextPC,
    input  logic        EX_PredTaken,
    input  logic [31:0] EX_PredPC,
    output logic        Redirect,
    output logic [31:0] RedirectPC
`ifdef BTB_STATS_EN
    ,
    output logic [31:0] StatLookups,
    output logic [31:0] StatHits,
    output logic [31:0] StatMispred
`endif
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        cnt_q    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]    if_tag, ex_tag;
    logic                ex_hit, upd, stale;

    logic              wr_en, wr_valid;
    logic [31:0]       wr_tgt;
    logic [1:0]        wr_cnt, ex_cnt;

    assign if_idx = IF_PC[IDX_BITS+1:2];
    assign if_tag = IF_PC[31:IDX_BITS+2];
    assign ex_idx = EX_PC[IDX_BITS+1:2];
    assign ex_tag = EX_PC[31:IDX_BITS+2];

    assign PredHit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign PredTaken = PredHit && cnt_q[if_idx][1];
    assign PredPC    = PredTaken ? target_q[if_idx] : IF_PC + 32'd4;

    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_cnt = cnt_q[ex_idx];
    assign upd    = EX_Valid && EX_BranchSig;
    assign stale  = EX_Valid && !EX_BranchSig && EX_PredTaken;

    assign Redirect = (upd && (EX_Branched != EX_PredTaken))
                   || (upd && EX_Branched && EX_PredTaken && (EX_PredPC != EX_NextPC))
                   || stale;
    assign RedirectPC = (upd && EX_Branched) ? EX_NextPC : EX_PC + 32'd4;

    always_comb begin
        wr_en    = 1'b0;
        wr_valid = 1'b1;
        wr_tgt   = target_q[ex_idx];
        wr_cnt   = ex_cnt;
        if (upd) begin
            if (ex_hit) begin
                wr_en = 1'b1;
                if (EX_Uncond) begin
                    wr_cnt = 2'd3;
                    wr_tgt = EX_NextPC;
                end else if (EX_Branched) begin
                    wr_cnt = (ex_cnt == 2'd3) ? 2'd3 : ex_cnt + 2'd1;
                    wr_tgt = EX_NextPC;
                end else begin
                    wr_cnt = (ex_cnt == 2'd0) ? 2'd0 : ex_cnt - 2'd1;
                end
            end else if (EX_Branched) begin
                wr_en  = 1'b1;
                wr_tgt = EX_NextPC;
                wr_cnt = EX_Uncond ? 2'd3 : 2'(CNT_INIT);
            end
        end else if (stale && ex_hit) begin
            // non-branch that was predicted taken: drop the aliasing entry
            wr_en    = 1'b1;
            wr_valid = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'd0;
            end
        end else if (wr_en) begin
            valid_q[ex_idx]  <= wr_valid;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= wr_tgt;
            cnt_q[ex_idx]    <= wr_cnt;
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            StatLookups <= '0;
            StatHits    <= '0;
            StatMispred <= '0;
        end else begin
            StatLookups <= StatLookups + 32'd1;
            if (PredHit)  StatHits    <= StatHits + 32'd1;
            if (Redirect) StatMispred <= StatMispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed vector table, async reset check, and random traffic vs a table model.
module tb_btb_predictor;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] IF_PC;
    logic        PredHit, PredTaken;
    logic [31:0] PredPC;
    logic        EX_Valid, EX_BranchSig, EX_Uncond, EX_Branched, EX_PredTaken;
    logic [31:0] EX_PC, EX_NextPC, EX_PredPC;
    logic        Redirect;
    logic [31:0] RedirectPC;
`ifdef BTB_STATS_EN
    logic [31:0] StatLookups, StatHits, StatMispred;
`endif

    btb_predictor dut (
        .CLK(CLK), .RST_N(RST_N), .IF_PC(IF_PC),
        .PredHit(PredHit), .PredTaken(PredTaken), .PredPC(PredPC),
        .EX_Valid(EX_Valid), .EX_PC(EX_PC), .EX_BranchSig(EX_BranchSig),
        .EX_Uncond(EX_Uncond), .EX_Branched(EX_Branched), .EX_NextPC(EX_NextPC),
        .EX_PredTaken(EX_PredTaken), .EX_PredPC(EX_PredPC),
        .Redirect(Redirect), .RedirectPC(RedirectPC)
`ifdef BTB_STATS_EN
        , .StatLookups(StatLookups), .StatHits(StatHits), .StatMispred(StatMispred)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference table: 16 entries, index = word address mod 16, tag = word address / 16
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_cnt   [16];

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic int unsigned mtag(input logic [31:0] pc);
        return int'(pc >> 6);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[midx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_predpc(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[midx(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic m_update();
        int i;
        i = midx(EX_PC);
        if (!EX_Valid) return;
        if (EX_BranchSig) begin
            if (m_hit(EX_PC)) begin
                if (EX_Uncond) begin
                    m_cnt[i] = 3; m_tgt[i] = EX_NextPC;
                end else if (EX_Branched) begin
                    m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
                    m_tgt[i] = EX_NextPC;
                end else begin
                    m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
                end
            end else if (EX_Branched) begin
                m_valid[i] = 1; m_tag[i] = mtag(EX_PC); m_tgt[i] = EX_NextPC;
                m_cnt[i] = EX_Uncond ? 3 : 2;
            end
        end else if (EX_PredTaken && m_hit(EX_PC)) begin
            m_valid[i] = 0;
        end
    endtask

    function automatic bit m_redirect();
        bit u;
        u = EX_Valid && EX_BranchSig;
        if (!EX_Valid) return 0;
        if (u && (EX_Branched != EX_PredTaken)) return 1;
        if (u && EX_Branched && EX_PredTaken && (EX_PredPC != EX_NextPC)) return 1;
        return !EX_BranchSig && EX_PredTaken;
    endfunction

    function automatic logic [31:0] m_redirpc();
        return (EX_Valid && EX_BranchSig && EX_Branched) ? EX_NextPC : EX_PC + 32'd4;
    endfunction

    typedef struct {
        logic [31:0] if_pc;
        logic        v, bsig, unc, br, pt;
        logic [31:0] ex_pc, nxt, ppc;
        logic        e_hit, e_tk;
        logic [31:0] e_ppc;
        logic        e_rd;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] if_pc, input logic v, input logic [31:0] ex_pc,
                       input logic bsig, input logic unc, input logic br, input logic [31:0] nxt,
                       input logic pt, input logic [31:0] ppc,
                       input logic e_hit, input logic e_tk, input logic [31:0] e_ppc,
                       input logic e_rd, input logic [31:0] e_rpc);
        vec_t t;
        t.if_pc = if_pc; t.v = v; t.ex_pc = ex_pc; t.bsig = bsig; t.unc = unc; t.br = br;
        t.nxt = nxt; t.pt = pt; t.ppc = ppc; t.e_hit = e_hit; t.e_tk = e_tk; t.e_ppc = e_ppc;
        t.e_rd = e_rd; t.e_rpc = e_rpc;
        vecs.push_back(t);
    endtask

    task automatic idle(input logic [31:0] if_pc, input logic e_hit, input logic e_tk, input logic [31:0] e_ppc);
        add(if_pc, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, e_hit, e_tk, e_ppc, 0, 32'h4);
    endtask

    task automatic drive(input vec_t t);
        IF_PC = t.if_pc; EX_Valid = t.v; EX_PC = t.ex_pc; EX_BranchSig = t.bsig;
        EX_Uncond = t.unc; EX_Branched = t.br; EX_NextPC = t.nxt;
        EX_PredTaken = t.pt; EX_PredPC = t.ppc;
    endtask

    logic [31:0] rnd_pc;

    function automatic logic [31:0] pool_pc();
        return 32'h0040_0000 | (32'($urandom_range(0, 47)) << 2);
    endfunction

    initial begin
        RST_N = 1'b0;
        drive('{if_pc: 32'h0040_0010, default: '0});
        #3;
        check("rst_hit", 32'(PredHit), 32'h0);
        check("rst_taken", 32'(PredTaken), 32'h0);
        check("rst_predpc", PredPC, 32'h0040_0014);
        m_reset();
        @(negedge CLK);
        RST_N = 1'b1;

        //   IF_PC        V  EX_PC        B  U  T  NextPC       PT PredPC      hit tk PredPC     rd RedirPC
        add(32'h00400010, 1, 32'h00400010, 1, 0, 1, 32'h00400040, 0, 32'h00400014, 0, 0, 32'h00400014, 1, 32'h00400040);
        idle(32'h00400010, 1, 1, 32'h00400040);
        add(32'h00400010, 1, 32'h00400010, 1, 0, 0, 32'h00400014, 1, 32'h00400040, 1, 1, 32'h00400040, 1, 32'h00400014);
        add(32'h00400010, 1, 32'h00400010, 1, 0, 0, 32'h00400014, 0, 32'h00400014, 1, 0, 32'h00400014, 0, 32'h00400014);
        add(32'h00400010, 1, 32'h00400010, 1, 0, 0, 32'h00400014, 0, 32'h00400014, 1, 0, 32'h00400014, 0, 32'h00400014);
        add(32'h00400010, 1, 32'h00400010, 1, 0, 1, 32'h00400040, 0, 32'h00400014, 1, 0, 32'h00400014, 1, 32'h00400040);
        idle(32'h00400010, 1, 0, 32'h00400014);
        add(32'h00400020, 1, 32'h00400020, 1, 1, 1, 32'h00400100, 0, 32'h00400024, 0, 0, 32'h00400024, 1, 32'h00400100);
        add(32'h00400020, 1, 32'h00400020, 1, 1, 1, 32'h00400200, 1, 32'h00400100, 1, 1, 32'h00400100, 1, 32'h00400200);
        idle(32'h00400020, 1, 1, 32'h00400200);
        add(32'h00400010, 1, 32'h00400050, 1, 0, 1, 32'h00400080, 0, 32'h00400054, 1, 0, 32'h00400014, 1, 32'h00400080);
        idle(32'h00400010, 0, 0, 32'h00400014);
        idle(32'h00400050, 1, 1, 32'h00400080);
        add(32'h00400060, 1, 32'h00400060, 1, 0, 1, 32'h00400300, 0, 32'h00400064, 0, 0, 32'h00400064, 1, 32'h00400300);
        add(32'h00400060, 1, 32'h00400060, 0, 0, 0, 32'h00400064, 1, 32'h00400300, 1, 1, 32'h00400300, 1, 32'h00400064);
        idle(32'h00400060, 0, 0, 32'h00400064);
        add(32'h00400050, 0, 32'h00400050, 1, 1, 1, 32'h00400900, 1, 32'h00400800, 1, 1, 32'h00400080, 0, 32'h00400054);
        idle(32'h00400050, 1, 1, 32'h00400080);
        idle(32'hFFFFFFFC, 0, 0, 32'h00000000);
        add(32'h00400050, 1, 32'h00400050, 1, 0, 1, 32'h00400080, 1, 32'h00400080, 1, 1, 32'h00400080, 0, 32'h00400080);
        add(32'h00400050, 1, 32'hFFFFFFFC, 0, 0, 0, 32'h00000000, 1, 32'h00001000, 1, 1, 32'h00400080, 1, 32'h00000000);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k]);
            #1;
            check($sformatf("v%0d_hit", k), 32'(PredHit), 32'(vecs[k].e_hit));
            check($sformatf("v%0d_taken", k), 32'(PredTaken), 32'(vecs[k].e_tk));
            check($sformatf("v%0d_predpc", k), PredPC, vecs[k].e_ppc);
            check($sformatf("v%0d_redirect", k), 32'(Redirect), 32'(vecs[k].e_rd));
            check($sformatf("v%0d_redirpc", k), RedirectPC, vecs[k].e_rpc);
            @(posedge CLK);
            m_update();
            @(negedge CLK);
        end

        // asynchronous reset mid-cycle
        drive('{if_pc: 32'h0040_0050, default: '0});
        #1;
        check("pre_async_hit", 32'(PredHit), 32'h1);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_hit", 32'(PredHit), 32'h0);
        check("async_rst_predpc", PredPC, 32'h0040_0054);
        m_reset();
        @(negedge CLK);
        RST_N = 1'b1;

        for (int k = 0; k < 400; k++) begin
            IF_PC        = pool_pc();
            EX_Valid     = ($urandom_range(0, 7) != 0);
            EX_PC        = pool_pc();
            EX_BranchSig = ($urandom_range(0, 3) != 0);
            EX_Uncond    = EX_BranchSig && ($urandom_range(0, 3) == 0);
            EX_Branched  = EX_Uncond || (EX_BranchSig && $urandom_range(0, 1) == 1);
            rnd_pc       = pool_pc();
            EX_NextPC    = EX_Branched ? rnd_pc : EX_PC + 32'd4;
            if ($urandom_range(0, 3) != 0) begin
                EX_PredTaken = m_taken(EX_PC);
                EX_PredPC    = m_predpc(EX_PC);
            end else begin
                EX_PredTaken = 1'($urandom_range(0, 1));
                EX_PredPC    = pool_pc();
            end
            #1;
            check("rnd_hit", 32'(PredHit), 32'(m_hit(IF_PC)));
            check("rnd_taken", 32'(PredTaken), 32'(m_taken(IF_PC)));
            check("rnd_predpc", PredPC, m_predpc(IF_PC));
            check("rnd_redirect", 32'(Redirect), 32'(m_redirect()));
            check("rnd_redirpc", RedirectPC, m_redirpc());
            @(posedge CLK);
            m_update();
            @(negedge CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Branch target buffer for the redirection pipeline.
- Looks up the IF-stage PC and supplies a predicted next PC.
- Consumes the EX-stage resolution produced by the PC update logic: branch-class flag, taken flag and resolved next PC.
- Updates its table from that resolution and raises a redirect with the corrected PC on a misprediction.

Parameters:
- IDX_BITS, 4, log2 of entry count (16 entries, direct-mapped).
- CNT_INIT, 2, 2-bit counter value written on allocation (2 = weakly taken).

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IF_PC  in  32  fetch-stage PC to look up.
- PredHit  out  1  valid entry with matching tag.
- PredTaken  out  1  PredHit & counter[1].
- PredPC  out  32  PredTaken ? stored target : IF_PC+4.
- EX_Valid  in  1  EX stage holds a real instruction (not a bubble).
- EX_PC  in  32  PC of the EX instruction.
- EX_BranchSig  in  1  EX instruction is beq/bne/blez/j/jal/jr.
- EX_Uncond  in  1  EX instruction is j/jal/jr.
- EX_Branched  in  1  resolved taken.
- EX_NextPC  in  32  resolved next PC (target if taken).
- EX_PredTaken  in  1  PredTaken carried down the pipeline with the instruction.
- EX_PredPC  in  32  PredPC carried down the pipeline.
- Redirect  out  1  misprediction; IF/ID must be flushed.
- RedirectPC  out  32  correct fetch PC.

Behaviour:
- Address split:
  - index = PC[IDX_BITS+1:2].
  - tag = PC[31:IDX_BITS+2].
  - PC[1:0] are ignored.
- Entry contents: valid, tag, target[31:0], cnt[1:0].
- Lookup is combinational on IF_PC, with zero latency.
  - No bypass: a same-cycle update to the same index is not visible until the next cycle.
- Reset (RST_N low, asynchronous):
  - all valid=0, all cnt=0, all targets=0.
  - Outputs follow: PredHit=0, PredTaken=0, PredPC=IF_PC+4.
  - Redirect stays combinational from the EX inputs.
  - Reset asserted mid-operation discards all entries immediately.
- Let U = EX_Valid & EX_BranchSig, evaluated at each rising edge.
- Update when U=1:
  - Entry at EX_PC hits, taken: cnt = min(cnt+1, 3); target = EX_NextPC.
  - Entry at EX_PC hits, not taken: cnt = max(cnt-1, 0); target unchanged.
  - Entry at EX_PC hits, EX_Uncond=1: cnt = 3; target = EX_NextPC.
  - Miss and taken: allocate; valid=1, tag from EX_PC, target = EX_NextPC.
    - cnt = 3 if EX_Uncond, else CNT_INIT.
    - Overwrites the previous occupant of that index.
  - Miss and not taken: no write.
- Stale entry:
  - Condition: EX_Valid=1, EX_BranchSig=0, EX_PredTaken=1 (non-branch predicted taken).
  - Entry at index(EX_PC) is invalidated if its tag matches EX_PC.
- No update when EX_Valid=0.
- Redirect (combinational), asserted when EX_Valid=1 and any of:
  - U & (EX_Branched != EX_PredTaken).
  - U & EX_Branched & EX_PredTaken & (EX_PredPC != EX_NextPC).
  - ~EX_BranchSig & EX_PredTaken.
- RedirectPC:
  - U & EX_Branched: EX_NextPC.
  - otherwise: EX_PC+4.
- Arithmetic: all PC adds are 32-bit modulo; 0xFFFFFFFC+4 = 0x00000000.
- Counter saturation: 3+1 stays 3; 0-1 stays 0.
- Simultaneous events:
  - A lookup and an update to the same entry in one cycle: the lookup returns pre-update data and the write lands at the edge.
  - A redirect cycle still performs its table update.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined: adds three 32-bit outputs, each cleared by RST_N.
  - StatLookups: increments each cycle.
  - StatHits: increments when PredHit=1.
  - StatMispred: increments when Redirect=1.
  - All three wrap at 2^32.
- Undefined: ports and counters are absent; no other behaviour changes.

Test Plan:
- Reset then IF_PC=0x00400010 -> PredHit=0, PredTaken=0, PredPC=0x00400014.
- EX beq at 0x00400010, taken, NextPC=0x00400040, EX_PredTaken=0 -> Redirect=1, RedirectPC=0x00400040. Next cycle, IF_PC=0x00400010 -> PredHit=1, PredTaken=1, PredPC=0x00400040.
- Same beq resolved not-taken twice (cnt 2->1->0), each with the matching prediction in EX_PredTaken:
  - First resolution -> Redirect=1, RedirectPC=0x00400014.
  - Afterwards lookup gives PredTaken=0, PredHit=1.
  - Third not-taken -> cnt stays 0.
- jr at 0x00400020:
  - Predicted target 0x00400100, actual 0x00400200 -> Redirect=1, RedirectPC=0x00400200, cnt=3, target updated.
- Aliasing:
  - Entry at 0x00400010; taken branch resolved at 0x00400050 (same index, different tag, IDX_BITS=4) -> entry replaced, lookup of 0x00400010 misses.
- Non-branch at 0x00400060 with EX_PredTaken=1 -> Redirect=1, RedirectPC=0x00400064, matching entry invalidated.
- EX_Valid=0 with all other EX inputs active -> Redirect=0, table unchanged.
- Assert RST_N low asynchronously mid-sequence -> PredHit drops to 0 without waiting for a clock edge.
